// File: rtl/motor_sched_pkg.sv
// Shared types and defaults for the motor move scheduler.
package motor_sched_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        ARM     = 2'd1,
        FIRE    = 2'd2
    } sched_state_t;

    localparam int DELTA_W_DEF    = 16;
    localparam int WDOG_TICKS_DEF = 167;

    // Low bit of channel k's slice in a packed per-channel bus.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/motor_move_scheduler_if.sv
// Host command stream into the motor move scheduler.
interface motor_move_scheduler_if
    import motor_sched_pkg::*;
#(
    parameter int CH_W    = 2,
    parameter int DELTA_W = DELTA_W_DEF
);

    logic               cmd_valid;
    logic               cmd_ready;
    logic [CH_W-1:0]    cmd_chan;
    logic [DELTA_W-1:0] cmd_delta;
    logic               cmd_last;

    modport master (
        output cmd_valid, cmd_chan, cmd_delta, cmd_last,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_chan, cmd_delta, cmd_last,
        output cmd_ready
    );

endinterface

// File: rtl/motor_sched_slot.sv
// One channel's staging delta, pending bit and launched deltaPos/pulse registers.
module motor_sched_slot
    import motor_sched_pkg::*;
#(
    parameter int DELTA_W = DELTA_W_DEF
) (
    input  logic               CLK_10MHZ,
    input  logic               RST_N,
    input  logic               load,
    input  logic [DELTA_W-1:0] load_delta,
    input  logic               fire,
    input  logic               clear,
    output logic               pend,
    output logic               pulse,
    output logic [DELTA_W-1:0] delta_out
);

    logic [DELTA_W-1:0] stage;

    // Output slice and pulse move on the same edge so the motor sees a stable delta.
    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            stage     <= '0;
            pend      <= 1'b0;
            pulse     <= 1'b0;
            delta_out <= '0;
        end else begin
            pulse <= fire & pend;
            if (fire && pend) begin
                delta_out <= stage;
            end
            if (load) begin
                stage <= load_delta;
                pend  <= 1'b1;
            end else if (fire || clear) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/motor_move_scheduler.sv
// Groups per-channel moves and launches them together on a clock_6ms tick.
// Optional ARM watchdog with sticky timeout output: define MOTOR_SCHED_WATCHDOG_EN.
//
// state   | meaning
// COLLECT | accepting commands into the pending group
// ARM     | group closed; waiting for a tick with all targeted channels idle
// FIRE    | launch pulse cycle; group cleared
module motor_move_scheduler
    import motor_sched_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int CH_W       = 2,
    parameter int DELTA_W    = DELTA_W_DEF,
    parameter int WDOG_TICKS = WDOG_TICKS_DEF
) (
    input  logic                      CLK_10MHZ,
    input  logic                      RST_N,
    input  logic                      clock_6ms,
    motor_move_scheduler_if.slave     cmd,
    input  logic [N_CH-1:0]           ch_busy,
    output logic [N_CH*DELTA_W-1:0]   deltaPos,
    output logic [N_CH-1:0]           newPosSignal,
    output logic                      err_dup,
    output logic                      err_chan,
    input  logic                      err_clr,
    output logic                      sched_busy
`ifdef MOTOR_SCHED_WATCHDOG_EN
    ,
    output logic                      timeout
`endif
);

    sched_state_t    state_q, state_d;
    logic            accept;
    logic            chan_ok;
    logic            dup_hit;
    logic            chan_err;
    logic            launch;
    logic            abort;
    logic            wdog_expire;
    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] hit;
    logic [N_CH-1:0] load_vec;

    assign cmd.cmd_ready = (state_q == COLLECT);
    assign sched_busy    = (state_q != COLLECT);
    assign accept        = cmd.cmd_valid & (state_q == COLLECT);
    assign chan_ok       = int'(cmd.cmd_chan) < N_CH;
    assign load_vec      = {N_CH{accept & chan_ok}} & hit & ~pend;
    assign dup_hit       = accept & chan_ok & (|(hit & pend));
    assign chan_err      = accept & ~chan_ok;

    for (genvar k = 0; k < N_CH; k++) begin : g_slot
        assign hit[k] = (int'(cmd.cmd_chan) == k);

        motor_sched_slot #(.DELTA_W(DELTA_W)) u_slot (
            .CLK_10MHZ  (CLK_10MHZ),
            .RST_N      (RST_N),
            .load       (load_vec[k]),
            .load_delta (cmd.cmd_delta),
            .fire       (launch),
            .clear      (abort),
            .pend       (pend[k]),
            .pulse      (newPosSignal[k]),
            .delta_out  (deltaPos[slice_lo(k, DELTA_W) +: DELTA_W])
        );
    end

    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Launch is checked before expiry so a tick that qualifies never times out.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept && cmd.cmd_last && ((pend | load_vec) != '0)) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (clock_6ms && ((ch_busy & pend) == '0)) begin
                    launch  = 1'b1;
                    state_d = FIRE;
                end else if (wdog_expire) begin
                    abort   = 1'b1;
                    state_d = COLLECT;
                end
            end
            FIRE: begin
                state_d = COLLECT;
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            err_dup  <= 1'b0;
            err_chan <= 1'b0;
        end else begin
            err_dup  <= dup_hit  | (err_dup  & ~err_clr);
            err_chan <= chan_err | (err_chan & ~err_clr);
        end
    end

`ifdef MOTOR_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_TICKS + 1);

    logic [WD_W-1:0] tick_cnt;

    assign wdog_expire = clock_6ms && (tick_cnt == WD_W'(WDOG_TICKS - 1));

    // Held at zero outside ARM, so every ARM entry starts a fresh count.
    always_ff @(posedge CLK_10MHZ or negedge RST_N) begin
        if (!RST_N) begin
            tick_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state_q != ARM) begin
                tick_cnt <= '0;
            end else if (clock_6ms) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            timeout <= abort | (timeout & ~err_clr);
        end
    end
`else
    // WDOG_TICKS only sizes the watchdog; without it ARM waits indefinitely.
    if (WDOG_TICKS < 0) begin : g_no_wdog
    end
    assign wdog_expire = 1'b0;
`endif

endmodule

// File: tb/tb_motor_move_scheduler.sv
// Self-checking bench: vector table, directed corner sequences, randomized groups vs a group-level model.
module tb_motor_move_scheduler;
    import motor_sched_pkg::*;

    localparam int N_CH = 4;
    localparam int CH_W = 3;
    localparam int DW   = 16;
`ifdef MOTOR_SCHED_WATCHDOG_EN
    localparam int TB_WDOG = 8;
`else
    localparam int TB_WDOG = 167;
`endif

    logic                 CLK_10MHZ = 1'b0;
    logic                 RST_N     = 1'b0;
    logic                 clock_6ms = 1'b0;
    logic                 err_clr   = 1'b0;
    logic [N_CH-1:0]      ch_busy   = '0;
    logic [N_CH-1:0]      newPosSignal;
    logic [N_CH*DW-1:0]   deltaPos;
    logic                 err_dup;
    logic                 err_chan;
    logic                 sched_busy;
`ifdef MOTOR_SCHED_WATCHDOG_EN
    logic                 timeout;
`endif

    motor_move_scheduler_if #(.CH_W(CH_W), .DELTA_W(DW)) cmd_if ();

    motor_move_scheduler #(
        .N_CH(N_CH), .CH_W(CH_W), .DELTA_W(DW), .WDOG_TICKS(TB_WDOG)
    ) dut (
        .CLK_10MHZ    (CLK_10MHZ),
        .RST_N        (RST_N),
        .clock_6ms    (clock_6ms),
        .cmd          (cmd_if),
        .ch_busy      (ch_busy),
        .deltaPos     (deltaPos),
        .newPosSignal (newPosSignal),
        .err_dup      (err_dup),
        .err_chan     (err_chan),
        .err_clr      (err_clr),
        .sched_busy   (sched_busy)
`ifdef MOTOR_SCHED_WATCHDOG_EN
        ,
        .timeout      (timeout)
`endif
    );

    always #50 CLK_10MHZ = ~CLK_10MHZ;

    int n_tests = 0;
    int n_fail  = 0;
    int pulse_cnt = 0;
    logic [DW-1:0] exp_dp [N_CH];

    always @(posedge CLK_10MHZ) begin
        if (|newPosSignal) pulse_cnt++;
    end

    typedef struct {
        int              chan;
        logic [DW-1:0]   delta;
        logic [N_CH-1:0] busy;
        int              gap;
        logic [N_CH-1:0] exp_mask;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N_CH*DW-1:0] exp_vec();
        logic [N_CH*DW-1:0] v;
        v = '0;
        for (int k = 0; k < N_CH; k++) v[k*DW +: DW] = exp_dp[k];
        return v;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge CLK_10MHZ);
    endtask

    task automatic send(input int chan, input logic [DW-1:0] delta, input logic last,
                        input logic clr = 1'b0);
        check("send_ready", 64'(cmd_if.cmd_ready), 64'd1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_chan  = CH_W'(chan);
        cmd_if.cmd_delta = delta;
        cmd_if.cmd_last  = last;
        err_clr          = clr;
        @(negedge CLK_10MHZ);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_last  = 1'b0;
        err_clr          = 1'b0;
    endtask

    task automatic tick(output logic [N_CH-1:0] m, output logic [N_CH*DW-1:0] d);
        clock_6ms = 1'b1;
        @(negedge CLK_10MHZ);
        clock_6ms = 1'b0;
        m = newPosSignal;
        d = deltaPos;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge CLK_10MHZ);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [N_CH-1:0]    m;
        logic [N_CH*DW-1:0] d;
        int                 pc;

        tbl[0] = '{chan: 1, delta: 16'h0200, busy: 4'b0000, gap: 5, exp_mask: 4'b0010};
        tbl[1] = '{chan: 3, delta: 16'hBEEF, busy: 4'b0001, gap: 0, exp_mask: 4'b1000};
        tbl[2] = '{chan: 0, delta: 16'h0001, busy: 4'b1110, gap: 2, exp_mask: 4'b0001};
        tbl[3] = '{chan: 2, delta: 16'hFFFF, busy: 4'b1011, gap: 1, exp_mask: 4'b0100};
        for (int k = 0; k < N_CH; k++) exp_dp[k] = '0;

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_chan  = '0;
        cmd_if.cmd_delta = '0;
        cmd_if.cmd_last  = 1'b0;

        idle(3);
        check("reset_ready", 64'(cmd_if.cmd_ready), 64'd1);
        check("reset_pulse", 64'(newPosSignal), 64'd0);
        check("reset_dpos",  64'(deltaPos), 64'd0);
        check("reset_errs",  64'({err_dup, err_chan}), 64'd0);
        check("reset_busy",  64'(sched_busy), 64'd0);
`ifdef MOTOR_SCHED_WATCHDOG_EN
        check("reset_timeout", 64'(timeout), 64'd0);
`endif
        RST_N = 1'b1;
        idle(2);

        // Vector table: one-command groups with busy bits only on other channels
        for (int i = 0; i < 4; i++) begin
            send(tbl[i].chan, tbl[i].delta, 1'b1);
            check("tbl_armed", 64'(sched_busy), 64'd1);
            ch_busy = tbl[i].busy;
            idle(tbl[i].gap);
            tick(m, d);
            check("tbl_mask", 64'(m), 64'(tbl[i].exp_mask));
            exp_dp[tbl[i].chan] = tbl[i].delta;
            check("tbl_dpos", 64'(d), 64'(exp_vec()));
            ch_busy = '0;
            idle(1);
            check("tbl_ready_back", 64'(cmd_if.cmd_ready), 64'd1);
        end

        // Group of three launched together
        send(0, 16'd10, 1'b0);
        send(2, 16'd20, 1'b0);
        send(3, 16'd30, 1'b1);
        check("grp_ready_arm", 64'(cmd_if.cmd_ready), 64'd0);
        idle(2);
        check("grp_ready_wait", 64'(cmd_if.cmd_ready), 64'd0);
        tick(m, d);
        check("grp_mask", 64'(m), 64'b1101);
        check("grp_ready_fire", 64'(cmd_if.cmd_ready), 64'd0);
        exp_dp[0] = 16'd10; exp_dp[2] = 16'd20; exp_dp[3] = 16'd30;
        check("grp_dpos", 64'(d), 64'(exp_vec()));
        idle(1);
        check("grp_ready_back", 64'(cmd_if.cmd_ready), 64'd1);

        // Busy hold: three blocked ticks, launch on the fourth
        send(2, 16'h0033, 1'b1);
        ch_busy = 4'b0101;
        for (int t = 0; t < 3; t++) begin
            tick(m, d);
            check("hold_blocked", 64'(m), 64'd0);
            idle(2);
        end
        ch_busy = 4'b0001;
        tick(m, d);
        check("hold_mask", 64'(m), 64'b0100);
        exp_dp[2] = 16'h0033;
        check("hold_dpos", 64'(d), 64'(exp_vec()));
        ch_busy = '0;
        idle(1);

        // Duplicate and invalid channel errors
        send(1, 16'd5, 1'b0);
        send(1, 16'd7, 1'b0);
        check("err_dup_set", 64'(err_dup), 64'd1);
        check("err_chan_clean", 64'(err_chan), 64'd0);
        send(7, 16'd9, 1'b1);
        check("err_chan_set", 64'(err_chan), 64'd1);
        check("err_armed", 64'(sched_busy), 64'd1);
        tick(m, d);
        check("err_mask", 64'(m), 64'b0010);
        exp_dp[1] = 16'd5;
        check("err_dpos_first", 64'(d), 64'(exp_vec()));
        idle(1);
        send(0, 16'd1, 1'b0);
        send(0, 16'd2, 1'b0, 1'b1);
        check("err_dup_wins_clr", 64'(err_dup), 64'd1);
        check("err_chan_cleared", 64'(err_chan), 64'd0);
        pulse_clr();
        check("err_dup_cleared", 64'(err_dup), 64'd0);
        send(3, 16'd3, 1'b1);
        tick(m, d);
        check("err2_mask", 64'(m), 64'b1001);
        exp_dp[0] = 16'd1; exp_dp[3] = 16'd3;
        check("err2_dpos", 64'(d), 64'(exp_vec()));
        idle(1);

        // Lone invalid cmd_last: nothing to launch
        pc = pulse_cnt;
        send(7, 16'h00AA, 1'b1);
        check("empty_state", 64'(sched_busy), 64'd0);
        check("empty_ready", 64'(cmd_if.cmd_ready), 64'd1);
        check("empty_err", 64'(err_chan), 64'd1);
        tick(m, d);
        check("empty_nopulse", 64'(m), 64'd0);
        idle(2);
        check("empty_pcnt", 64'(pulse_cnt), 64'(pc));
        pulse_clr();

        // Reset while ARM discards the group
        send(2, 16'h0077, 1'b1);
        check("rst_armed", 64'(sched_busy), 64'd1);
        RST_N = 1'b0;
        #1;
        check("rst_pulse", 64'(newPosSignal), 64'd0);
        check("rst_dpos", 64'(deltaPos), 64'd0);
        check("rst_ready", 64'(cmd_if.cmd_ready), 64'd1);
        check("rst_state", 64'(sched_busy), 64'd0);
        for (int k = 0; k < N_CH; k++) exp_dp[k] = '0;
        idle(2);
        RST_N = 1'b1;
        idle(1);
        pc = pulse_cnt;
        for (int t = 0; t < 3; t++) begin
            tick(m, d);
            check("rst_nopulse", 64'(m), 64'd0);
        end
        idle(2);
        check("rst_pcnt", 64'(pulse_cnt), 64'(pc));

`ifdef MOTOR_SCHED_WATCHDOG_EN
        // Watchdog expiry, then a launch on the would-be expiry tick
        send(1, 16'h0011, 1'b1);
        ch_busy = 4'b0010;
        for (int t = 1; t < TB_WDOG; t++) begin
            tick(m, d);
            check("wd_blocked", 64'(m), 64'd0);
            check("wd_not_yet", 64'(timeout), 64'd0);
        end
        tick(m, d);
        check("wd_nopulse", 64'(m), 64'd0);
        check("wd_timeout", 64'(timeout), 64'd1);
        check("wd_collect", 64'(sched_busy), 64'd0);
        ch_busy = '0;
        pulse_clr();
        check("wd_cleared", 64'(timeout), 64'd0);
        send(1, 16'h0022, 1'b1);
        ch_busy = 4'b0010;
        for (int t = 1; t < TB_WDOG; t++) begin
            tick(m, d);
            check("wd2_blocked", 64'(m), 64'd0);
        end
        ch_busy = '0;
        tick(m, d);
        check("wd2_mask", 64'(m), 64'b0010);
        check("wd2_timeout", 64'(timeout), 64'd0);
        exp_dp[1] = 16'h0022;
        check("wd2_dpos", 64'(d), 64'(exp_vec()));
        idle(1);
`endif

        // Randomized groups against a group-level model
        for (int g = 0; g < 40; g++) begin
            int              ncmd;
            logic [N_CH-1:0] pm;
            logic [DW-1:0]   st [N_CH];
            logic            ed, ec, launched;
            int              nt;
            ncmd = $urandom_range(1, 4);
            pm = '0; ed = 1'b0; ec = 1'b0;
            for (int k = 0; k < N_CH; k++) st[k] = '0;
            for (int c = 0; c < ncmd; c++) begin
                int            ch;
                logic [DW-1:0] dl;
                ch = $urandom_range(0, 5);
                dl = DW'($urandom);
                if (ch >= N_CH) ec = 1'b1;
                else if (pm[ch]) ed = 1'b1;
                else begin
                    pm[ch] = 1'b1;
                    st[ch] = dl;
                end
                send(ch, dl, c == ncmd - 1);
            end
            check("rnd_err_dup", 64'(err_dup), 64'(ed));
            check("rnd_err_chan", 64'(err_chan), 64'(ec));
            check("rnd_armed", 64'(sched_busy), 64'(pm != '0));
            if (pm == '0) begin
                tick(m, d);
                check("rnd_empty", 64'(m), 64'd0);
            end else begin
                launched = 1'b0;
                nt = 0;
                while (!launched) begin
                    logic [N_CH-1:0] bz, em;
                    bz = (nt >= 4) ? '0 : N_CH'($urandom);
                    ch_busy = bz;
                    idle($urandom_range(0, 2));
                    tick(m, d);
                    em = ((bz & pm) == '0) ? pm : '0;
                    check("rnd_mask", 64'(m), 64'(em));
                    if (em != '0) begin
                        for (int k = 0; k < N_CH; k++) if (pm[k]) exp_dp[k] = st[k];
                        check("rnd_dpos", 64'(d), 64'(exp_vec()));
                        launched = 1'b1;
                    end
                    nt++;
                end
            end
            ch_busy = '0;
            idle(1);
            pulse_clr();
            check("rnd_errs_clr", 64'({err_dup, err_chan}), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
